regfile_wport_arbiter: RTL and testbench
========================================

# regfile_wport_arbiter

Sequencer and arbiter for the 32 x 32-bit register file's single write port. After every reset it zero-fills all 32 registers through the write port. It then shares the port between the CPU writeback path and a debug/loader port. CPU writeback has fixed priority; a starvation counter guarantees the debug port a slot. Sits between the CPU core/debug unit and the register file's `we`/`write_reg`/`write_data` inputs.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width (2^ADDR_W registers cleared)
- `STARVE_LIMIT`, 4, consecutive lost debug cycles before a forced debug slot (>=1)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_we`  in  1  CPU writeback request
- `cpu_waddr`  in  ADDR_W  CPU destination register
- `cpu_wdata`  in  DATA_W  CPU writeback data
- `cpu_stall`  out  1  CPU must hold its writeback; write not performed this cycle
- `dbg_req`  in  1  debug write request
- `dbg_waddr`  in  ADDR_W  debug destination register
- `dbg_wdata`  in  DATA_W  debug write data
- `dbg_gnt`  out  1  debug write performed at this clock edge
- `rf_we`  out  1  to register file `we`
- `rf_waddr`  out  ADDR_W  to register file `write_reg`
- `rf_wdata`  out  DATA_W  to register file `write_data`
- `busy`  out  1  clear sequence in progress

## Operation
- States: CLEAR, RUN, FORCE. Registers: `state`, `clr_cnt` (ADDR_W bits), `wait_cnt` (`$clog2(STARVE_LIMIT+1)` bits).
- `rst`=1: next state is CLEAR, `clr_cnt`=0, `wait_cnt`=0. `rst` overrides all other inputs.
- While `rst`=1, outputs are forced to `rf_we`=0, `busy`=1, `cpu_stall`=1, `dbg_gnt`=0.
- CLEAR outputs:
  - `rf_we`=1, `rf_waddr`=`clr_cnt`, `rf_wdata`=0.
  - `busy`=1, `cpu_stall`=1, `dbg_gnt`=0.
- CLEAR counting: `clr_cnt` increments each cycle. Register 0 is included in the clear.
- CLEAR exit: on the cycle with `clr_cnt`=2^ADDR_W-1, next state is RUN and `clr_cnt` wraps to 0.
- RUN, `cpu_we`=1: CPU wins. `rf_we`=1, `rf_waddr`=`cpu_waddr`, `rf_wdata`=`cpu_wdata`.
- RUN, `cpu_we`=0 and `dbg_req`=1: debug wins. The `rf_*` outputs carry the debug fields and `dbg_gnt`=1.
- RUN, neither requests: `rf_we`=0.
- RUN always drives `cpu_stall`=0.
- Address 0 writes from CPU or debug are suppressed: `rf_we`=0. The request is still treated as served, so `dbg_gnt`=1 for debug.
- `wait_cnt` in RUN:
  - Increments when `dbg_req`=1 and `cpu_we`=1 (debug lost).
  - Clears to 0 when `dbg_req`=0 or debug is granted.
- Entering FORCE: in RUN, if debug loses while `wait_cnt`=`STARVE_LIMIT`-1, the next state is FORCE.
- FORCE outputs: `cpu_stall`=1 and the CPU write is not performed. If `dbg_req`=1, debug is granted as in RUN. If `dbg_req`=0 (request withdrawn), `rf_we`=0 and `dbg_gnt`=0.
- FORCE exit: always returns to RUN with `wait_cnt`=0.
- Debug handshake:
  - The requester holds `dbg_req`, `dbg_waddr` and `dbg_wdata` stable until it samples `dbg_gnt`=1.
  - It may present a new request in the following cycle.
  - Withdrawing `dbg_req` before grant is legal; no write occurs.
- CPU handshake: when `cpu_stall`=1, the CPU repeats the same writeback next cycle.

## Timing
- Write port control outputs (`rf_*`, `dbg_gnt`, `cpu_stall`) are combinational from state and inputs. `busy` is a function of state and `rst` only.
- The register file commits the write at the same rising edge the grant is shown, so write latency is 0 cycles from request.
- Clear takes exactly 2^ADDR_W cycles (32 by default) after the first clock edge with `rst`=0. The first RUN cycle is cycle 32 after reset release.
- Worst-case debug latency from `dbg_req` rising in RUN: `STARVE_LIMIT`+1 cycles (5 by default).
- CPU throughput loss: one stall per `STARVE_LIMIT`+1 cycles under continuous contention.
- Reset mid-CLEAR or mid-FORCE aborts immediately. CLEAR restarts from address 0. A pending debug request is not granted until the new CLEAR completes.

## Test plan
- **Reset clear:** hold `rst` for 2 cycles, release. Require `rf_we`=1 with `rf_waddr` 0..31 and `rf_wdata`=0 on 32 consecutive cycles, `busy`=1 and `cpu_stall`=1 throughout. Then require `busy`=0, and register file reads return 0.
- **CPU priority:** in RUN, `cpu_we`=1 (addr 5, data 0xDEADBEEF) together with `dbg_req` (addr 6, data 0x12345678). Require CPU write to r5, `dbg_gnt`=0. The next cycle, with `cpu_we`=0, requires `dbg_gnt`=1 and r6=0x12345678.
- **Starvation:** continuous `cpu_we`=1 with incrementing data, `dbg_req`=1 held.
  - Require `dbg_gnt`=0 for 4 cycles, then on cycle 5 `cpu_stall`=1, `dbg_gnt`=1, and the debug data written.
  - The CPU's stalled write must land in the following cycle.
- **Address 0:** CPU writes 0xFFFFFFFF to r0 and debug writes to r0. Require `rf_we`=0 both times, `dbg_gnt`=1 for the debug write, and R1 read of r0 = 0.
- **Withdrawn request in FORCE:** reach FORCE, then drop `dbg_req` that cycle. Require `cpu_stall`=1, `rf_we`=0, `dbg_gnt`=0, then a return to RUN with `wait_cnt`=0.
- **Reset mid-clear:** assert `rst` when `clr_cnt`=17 while `dbg_req`=1. After release, require CLEAR to restart at address 0, run a full 32 cycles, and grant debug only in the first RUN cycle.

Source files
------------

// File: rtl/regfile_wport_arbiter_if.sv
// rtl/regfile_wport_arbiter_if.sv - CPU/debug request side and register file write-port side of the arbiter
interface regfile_wport_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_waddr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_waddr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              busy;

   modport master (
      output cpu_we, cpu_waddr, cpu_wdata, dbg_req, dbg_waddr, dbg_wdata,
      input  cpu_stall, dbg_gnt, rf_we, rf_waddr, rf_wdata, busy
   );

   modport slave (
      input  cpu_we, cpu_waddr, cpu_wdata, dbg_req, dbg_waddr, dbg_wdata,
      output cpu_stall, dbg_gnt, rf_we, rf_waddr, rf_wdata, busy
   );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - zero-fills the register file after reset, then arbitrates its write port
module regfile_wport_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input logic                   clk,
   input logic                   rst,
   regfile_wport_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {CLEAR, RUN, FORCE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_cnt, clr_nxt;
   logic [CNT_W-1:0]  wait_cnt, wait_nxt;

   logic              rf_we, cpu_stall, dbg_gnt, busy;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CLEAR;
         clr_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         clr_cnt  <= clr_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_cnt;
      wait_nxt  = wait_cnt;
      rf_we     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      cpu_stall = 1'b0;
      dbg_gnt   = 1'b0;
      busy      = 1'b0;
      case (state)
         CLEAR: begin
            rf_we     = 1'b1;
            rf_waddr  = clr_cnt;
            busy      = 1'b1;
            cpu_stall = 1'b1;
            clr_nxt   = clr_cnt + 1'b1;
            if (clr_cnt == {ADDR_W{1'b1}}) state_nxt = RUN;
         end
         RUN: begin
            if (bus.cpu_we) begin
               // r0 is hardwired zero: the write is accepted but never reaches the file
               rf_we    = (bus.cpu_waddr != '0);
               rf_waddr = bus.cpu_waddr;
               rf_wdata = bus.cpu_wdata;
               if (bus.dbg_req) begin
                  wait_nxt = wait_cnt + 1'b1;
                  if (wait_cnt == CNT_W'(STARVE_LIMIT - 1)) state_nxt = FORCE;
               end else begin
                  wait_nxt = '0;
               end
            end else begin
               wait_nxt = '0;
               if (bus.dbg_req) begin
                  dbg_gnt  = 1'b1;
                  rf_we    = (bus.dbg_waddr != '0);
                  rf_waddr = bus.dbg_waddr;
                  rf_wdata = bus.dbg_wdata;
               end
            end
         end
         FORCE: begin
            cpu_stall = 1'b1;
            state_nxt = RUN;
            wait_nxt  = '0;
            if (bus.dbg_req) begin
               dbg_gnt  = 1'b1;
               rf_we    = (bus.dbg_waddr != '0);
               rf_waddr = bus.dbg_waddr;
               rf_wdata = bus.dbg_wdata;
            end
         end
         default: state_nxt = CLEAR;
      endcase
      if (rst) begin
         rf_we     = 1'b0;
         busy      = 1'b1;
         cpu_stall = 1'b1;
         dbg_gnt   = 1'b0;
      end
   end

   assign bus.rf_we     = rf_we;
   assign bus.rf_waddr  = rf_waddr;
   assign bus.rf_wdata  = rf_wdata;
   assign bus.cpu_stall = cpu_stall;
   assign bus.dbg_gnt   = dbg_gnt;
   assign bus.busy      = busy;
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb/tb_regfile_wport_arbiter.sv - directed self-checking bench for regfile_wport_arbiter
module tb_regfile_wport_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] rf_model [32];

   regfile_wport_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regfile_wport_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Register file stand-in: commits on the same edge the write is presented
   always @(posedge clk) if (bus.rf_we) rf_model[bus.rf_waddr] <= bus.rf_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_seq(input string tag);
      for (int i = 0; i < 32; i++) begin
         #1;
         chk1({tag, "_we"}, bus.rf_we, 1'b1);
         chk({tag, "_addr"}, 32'(bus.rf_waddr), 32'(i));
         chk({tag, "_data"}, bus.rf_wdata, 32'h0);
         chk1({tag, "_busy"}, bus.busy, 1'b1);
         chk1({tag, "_stall"}, bus.cpu_stall, 1'b1);
         chk1({tag, "_gnt"}, bus.dbg_gnt, 1'b0);
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.cpu_we = 1'b0; bus.cpu_waddr = '0; bus.cpu_wdata = '0;
      bus.dbg_req = 1'b1; bus.dbg_waddr = 5'd3; bus.dbg_wdata = 32'h33;

      // reset held two cycles; debug request must not be granted
      tick();
      chk1("rst_we", bus.rf_we, 1'b0);
      chk1("rst_busy", bus.busy, 1'b1);
      chk1("rst_stall", bus.cpu_stall, 1'b1);
      chk1("rst_gnt", bus.dbg_gnt, 1'b0);
      tick();
      rst = 1'b0;
      bus.dbg_req = 1'b0;

      clear_seq("clear");
      #1;
      chk1("run_busy", bus.busy, 1'b0);
      chk1("run_stall", bus.cpu_stall, 1'b0);
      chk1("run_idle_we", bus.rf_we, 1'b0);
      for (int i = 0; i < 32; i++) chk("cleared_reg", rf_model[i], 32'h0);

      // CPU priority over debug
      bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd5; bus.cpu_wdata = 32'hDEADBEEF;
      bus.dbg_req = 1'b1; bus.dbg_waddr = 5'd6; bus.dbg_wdata = 32'h12345678;
      #1;
      chk1("prio_we", bus.rf_we, 1'b1);
      chk("prio_addr", 32'(bus.rf_waddr), 32'd5);
      chk("prio_data", bus.rf_wdata, 32'hDEADBEEF);
      chk1("prio_gnt", bus.dbg_gnt, 1'b0);
      tick();
      bus.cpu_we = 1'b0;
      #1;
      chk1("dbg_gnt", bus.dbg_gnt, 1'b1);
      chk("dbg_addr", 32'(bus.rf_waddr), 32'd6);
      tick();
      bus.dbg_req = 1'b0;
      chk("r5", rf_model[5], 32'hDEADBEEF);
      chk("r6", rf_model[6], 32'h12345678);

      // starvation: four losses, forced slot on the fifth cycle
      bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd7;
      bus.dbg_req = 1'b1; bus.dbg_waddr = 5'd8; bus.dbg_wdata = 32'hCAFE0008;
      for (int c = 0; c < 4; c++) begin
         bus.cpu_wdata = 32'h100 + 32'(c);
         #1;
         chk1("starve_gnt", bus.dbg_gnt, 1'b0);
         chk1("starve_stall", bus.cpu_stall, 1'b0);
         chk("starve_cpu_data", bus.rf_wdata, 32'h100 + 32'(c));
         tick();
      end
      bus.cpu_wdata = 32'h104;
      #1;
      chk1("force_stall", bus.cpu_stall, 1'b1);
      chk1("force_gnt", bus.dbg_gnt, 1'b1);
      chk("force_addr", 32'(bus.rf_waddr), 32'd8);
      chk("force_data", bus.rf_wdata, 32'hCAFE0008);
      tick();
      bus.dbg_req = 1'b0;
      #1;
      chk1("retry_stall", bus.cpu_stall, 1'b0);
      chk1("retry_we", bus.rf_we, 1'b1);
      chk("retry_data", bus.rf_wdata, 32'h104);
      tick();
      chk("r8", rf_model[8], 32'hCAFE0008);
      chk("r7", rf_model[7], 32'h104);

      // writes to r0 are swallowed
      bus.cpu_waddr = 5'd0; bus.cpu_wdata = 32'hFFFFFFFF;
      #1;
      chk1("r0_cpu_we", bus.rf_we, 1'b0);
      chk1("r0_cpu_stall", bus.cpu_stall, 1'b0);
      tick();
      bus.cpu_we = 1'b0;
      bus.dbg_req = 1'b1; bus.dbg_waddr = 5'd0; bus.dbg_wdata = 32'h55;
      #1;
      chk1("r0_dbg_we", bus.rf_we, 1'b0);
      chk1("r0_dbg_gnt", bus.dbg_gnt, 1'b1);
      tick();
      bus.dbg_req = 1'b0;
      chk("r0", rf_model[0], 32'h0);

      // request withdrawn in the forced slot
      bus.cpu_we = 1'b1; bus.cpu_waddr = 5'd9;
      bus.dbg_req = 1'b1; bus.dbg_waddr = 5'd10; bus.dbg_wdata = 32'hAA;
      for (int c = 0; c < 4; c++) begin
         bus.cpu_wdata = 32'h200 + 32'(c);
         tick();
      end
      bus.cpu_wdata = 32'h204;
      bus.dbg_req = 1'b0;
      #1;
      chk1("wd_stall", bus.cpu_stall, 1'b1);
      chk1("wd_we", bus.rf_we, 1'b0);
      chk1("wd_gnt", bus.dbg_gnt, 1'b0);
      tick();
      chk("wd_wait_cnt", 32'(dut.wait_cnt), 32'd0);
      chk1("wd_run_stall", bus.cpu_stall, 1'b0);
      chk1("wd_run_we", bus.rf_we, 1'b1);
      chk("wd_run_data", bus.rf_wdata, 32'h204);
      tick();
      bus.cpu_we = 1'b0;
      chk("r10_untouched", rf_model[10], 32'h0);

      // reset mid-clear with a pending debug request
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 17; i++) tick();
      chk("midclr_addr", 32'(bus.rf_waddr), 32'd17);
      rst = 1'b1;
      bus.dbg_req = 1'b1; bus.dbg_waddr = 5'd11; bus.dbg_wdata = 32'h77;
      #1;
      chk1("midclr_rst_we", bus.rf_we, 1'b0);
      chk1("midclr_rst_gnt", bus.dbg_gnt, 1'b0);
      chk1("midclr_rst_busy", bus.busy, 1'b1);
      tick();
      rst = 1'b0;
      clear_seq("reclear");
      #1;
      chk1("reclear_gnt", bus.dbg_gnt, 1'b1);
      chk("reclear_addr", 32'(bus.rf_waddr), 32'd11);
      chk("reclear_data", bus.rf_wdata, 32'h77);
      tick();
      bus.dbg_req = 1'b0;
      chk("r11", rf_model[11], 32'h77);
      chk("r5_recleared", rf_model[5], 32'h0);
      chk1("reclear_busy", bus.busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
